// File: rtl/i2s_rx_core.sv
// I2S receiver: oversamples the I2S pins on aud_mclk, deserialises left/right samples
// into a small FIFO and drains them on an AXI-Stream master port.
module i2s_rx_core #(
  parameter int AUD_WIDTH       = 24,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXIS_TID_WIDTH  = 3,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                         aud_mclk,
  input  logic                         aud_mrst,
  input  logic                         enable,
  input  logic                         sclk_in,
  input  logic                         lrclk_in,
  input  logic                         sdata_in,
  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_aud_tdata,
  output logic [AXIS_TID_WIDTH-1:0]    m_axis_aud_tid,
  output logic                         m_axis_aud_tvalid,
  input  logic                         m_axis_aud_tready,
  input  logic                         clr_status,
  output logic                         overflow,
  output logic                         frame_err,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(AUD_WIDTH + 1);
  localparam int ENT_W = AUD_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SHIFT = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  // Pin sampling and edge detect
  logic             sclk_s_q, lrclk_s_q, sdata_s_q, sclk_d_q;
  logic             ws_prev_q, ws_prev_d;
  logic             sclk_rise, ws, ws_edge;

  // Capture FSM
  state_t           state_q, state_d;
  logic             chan_q, chan_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [AUD_WIDTH-1:0] shift_q, shift_d;
  logic             push_q, push_d;
  logic [ENT_W-1:0] push_data_q, push_data_d;
  logic             ferr_set;

  // FIFO and status
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d, frame_err_q, frame_err_d;
  logic             fifo_full, pop, do_push, ovf_set;
  logic [ENT_W-1:0] head;

  assign sclk_rise = sclk_s_q & ~sclk_d_q;
  assign ws        = lrclk_s_q;
  assign ws_edge   = ws != ws_prev_q;
  assign ws_prev_d = sclk_rise ? ws : ws_prev_q;

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    ferr_set    = 1'b0;
    if (!enable) begin
      // Dropping enable abandons any partial word; the FIFO keeps draining.
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (sclk_rise) begin
      case (state_q)
        ST_IDLE: begin
          if (ws_edge) begin
            chan_d  = ws;
            state_d = ST_DELAY;
          end
        end
        ST_DELAY: begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
        ST_SHIFT: begin
          if (ws_edge) begin
            ferr_set  = 1'b1;
            chan_d    = ws;
            bit_cnt_d = '0;
            state_d   = ST_DELAY;
          end else begin
            shift_d = {shift_q[AUD_WIDTH-2:0], sdata_s_q};
            if (bit_cnt_q == CNT_W'(AUD_WIDTH - 1)) begin
              push_d      = 1'b1;
              push_data_d = {chan_q, shift_q[AUD_WIDTH-2:0], sdata_s_q};
              bit_cnt_d   = '0;
              state_d     = ST_WAIT;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_WAIT: begin
          if (ws_edge) begin
            chan_d  = ws;
            state_d = ST_DELAY;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // AXI-Stream: a beat transfers on a cycle where tvalid & tready are both high; the head
  // entry is held on tdata/tid until then.
  assign m_axis_aud_tvalid = level_q != '0;
  assign fifo_full         = level_q == LVL_W'(FIFO_DEPTH);
  assign pop               = m_axis_aud_tvalid & m_axis_aud_tready;
  assign do_push           = push_q & (~fifo_full | pop);
  assign ovf_set           = push_q & fifo_full & ~pop;
  assign head              = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!do_push && pop) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Setting a sticky flag wins over a simultaneous clear.
  always_comb begin
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    if (clr_status) begin
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
    end
    if (ovf_set) begin
      overflow_d = 1'b1;
    end
    if (ferr_set) begin
      frame_err_d = 1'b1;
    end
  end

  always_comb begin
    m_axis_aud_tdata = '0;
    m_axis_aud_tid   = '0;
    if (m_axis_aud_tvalid) begin
      m_axis_aud_tdata[AUD_WIDTH+3:4] = head[AUD_WIDTH-1:0];
      m_axis_aud_tid[0]               = head[AUD_WIDTH];
    end
  end

  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;
  assign fifo_level = level_q;

  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      sclk_s_q    <= 1'b0;
      lrclk_s_q   <= 1'b0;
      sdata_s_q   <= 1'b0;
      sclk_d_q    <= 1'b0;
      ws_prev_q   <= 1'b0;
      state_q     <= ST_IDLE;
      chan_q      <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_s_q    <= sclk_in;
      lrclk_s_q   <= lrclk_in;
      sdata_s_q   <= sdata_in;
      sclk_d_q    <= sclk_s_q;
      ws_prev_q   <= ws_prev_d;
      state_q     <= state_d;
      chan_q      <= chan_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_i2s_rx_core.sv
// Directed bench for i2s_rx_core: drives I2S slots at sclk = mclk/2 and checks the
// AXI-Stream output, FIFO level and sticky status flags.
module tb_i2s_rx_core;

  logic        aud_mclk;
  logic        aud_mrst;
  logic        enable;
  logic        sclk_in;
  logic        lrclk_in;
  logic        sdata_in;
  logic [31:0] m_axis_aud_tdata;
  logic [2:0]  m_axis_aud_tid;
  logic        m_axis_aud_tvalid;
  logic        m_axis_aud_tready;
  logic        clr_status;
  logic        overflow;
  logic        frame_err;
  logic [2:0]  fifo_level;

  int tests_run;
  int tests_failed;

  // Beat = {tid, tdata}
  logic [34:0] got_q[$];
  logic [34:0] exp_q[$];

  i2s_rx_core #(
    .AUD_WIDTH(24),
    .AXIS_DATA_WIDTH(32),
    .AXIS_TID_WIDTH(3),
    .FIFO_DEPTH(4)
  ) dut (
    .aud_mclk(aud_mclk),
    .aud_mrst(aud_mrst),
    .enable(enable),
    .sclk_in(sclk_in),
    .lrclk_in(lrclk_in),
    .sdata_in(sdata_in),
    .m_axis_aud_tdata(m_axis_aud_tdata),
    .m_axis_aud_tid(m_axis_aud_tid),
    .m_axis_aud_tvalid(m_axis_aud_tvalid),
    .m_axis_aud_tready(m_axis_aud_tready),
    .clr_status(clr_status),
    .overflow(overflow),
    .frame_err(frame_err),
    .fifo_level(fifo_level)
  );

  // Clock / reset
  initial aud_mclk = 1'b0;
  always #5 aud_mclk = ~aud_mclk;

  // Records every accepted beat; inputs change on negedge, so #1 later they are settled
  always @(negedge aud_mclk) begin
    #1;
    if (m_axis_aud_tvalid === 1'b1 && m_axis_aud_tready === 1'b1)
      got_q.push_back({m_axis_aud_tid, m_axis_aud_tdata});
  end

  // One slot position per sclk period. Position 0 is the ws-edge rise, 1 the delay slot,
  // 2..25 carry sample bits 23..0, later positions are padding (random junk).
  task automatic send_slot(input logic ws, input logic [23:0] smp, input int first_p,
                           input int last_p, input bit pop_lsb);
    logic d;
    for (int p = first_p; p <= last_p; p++) begin
      if (p >= 2 && p <= 25) d = smp[25-p];
      else d = 1'($urandom_range(0, 1));
      @(negedge aud_mclk);
      sclk_in  = 1'b0;
      lrclk_in = ws;
      sdata_in = d;
      if (pop_lsb && p == 27) m_axis_aud_tready = 1'b0;
      @(negedge aud_mclk);
      sclk_in = 1'b1;
      if (pop_lsb && p == 26) m_axis_aud_tready = 1'b1;
    end
  endtask

  // Right-channel slot with capture disabled, so the next left slot starts on a ws edge
  task automatic preamble;
    enable = 1'b0;
    send_slot(1'b1, 24'h0, 0, 7, 1'b0);
    @(negedge aud_mclk);
    enable = 1'b1;
  endtask

  task automatic wait_beats(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 400) begin
      @(negedge aud_mclk);
      t++;
    end
  endtask

  task automatic finish_scenario;
    repeat (4) @(negedge aud_mclk);
    enable = 1'b0;
    m_axis_aud_tready = 1'b1;
    repeat (20) @(negedge aud_mclk);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_clr;
    @(negedge aud_mclk);
    clr_status = 1'b1;
    @(negedge aud_mclk);
    clr_status = 1'b0;
  endtask

  task automatic check_beats(input string name);
    logic [34:0] got;
    tests_run++;
    if (got_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL %s beat_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < got_q.size()) ? got_q[i] : 35'bx;
      tests_run++;
      if (got !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL %s beat%0d got=%h exp=%h", name, i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset;
    @(negedge aud_mclk);
    aud_mrst = 1'b1;
    repeat (3) begin
      enable            = 1'($urandom_range(0, 1));
      sclk_in           = 1'($urandom_range(0, 1));
      lrclk_in          = 1'($urandom_range(0, 1));
      sdata_in          = 1'($urandom_range(0, 1));
      m_axis_aud_tready = 1'($urandom_range(0, 1));
      clr_status        = 1'($urandom_range(0, 1));
      @(negedge aud_mclk);
    end
    aud_mrst = 1'b0; enable = 1'b0; sclk_in = 1'b0; lrclk_in = 1'b0; sdata_in = 1'b0;
    m_axis_aud_tready = 1'b0; clr_status = 1'b0;
    tests_run++;
    if (m_axis_aud_tvalid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_aud_tvalid);
    end
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++; $display("FAIL reset_overflow got=%b exp=0", overflow);
    end
    tests_run++;
    if (frame_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_frame_err got=%b exp=0", frame_err);
    end
    tests_run++;
    if (fifo_level !== 3'd0) begin
      tests_failed++; $display("FAIL reset_level got=%0d exp=0", fifo_level);
    end
    tests_run++;
    if (m_axis_aud_tdata !== 32'h0) begin
      tests_failed++; $display("FAIL reset_tdata got=%h exp=0", m_axis_aud_tdata);
    end
    tests_run++;
    if (m_axis_aud_tid !== 3'd0) begin
      tests_failed++; $display("FAIL reset_tid got=%0d exp=0", m_axis_aud_tid);
    end
  endtask

  task automatic test_basic_frame;
    m_axis_aud_tready = 1'b1;
    preamble();
    send_slot(1'b0, 24'hA5A5A5, 0, 31, 1'b0);
    send_slot(1'b1, 24'h5A5A5A, 0, 31, 1'b0);
    exp_q.push_back({3'd0, 32'h0A5A5A50});
    exp_q.push_back({3'd1, 32'h05A5A5A0});
    wait_beats(2);
    repeat (10) @(negedge aud_mclk);
    check_beats("basic");
    tests_run++;
    if (frame_err !== 1'b0) begin
      tests_failed++; $display("FAIL basic_frame_err got=%b exp=0", frame_err);
    end
    finish_scenario();
  endtask

  task automatic test_backpressure;
    m_axis_aud_tready = 1'b0;
    preamble();
    send_slot(1'b0, 24'h111111, 0, 31, 1'b0);
    send_slot(1'b1, 24'h222222, 0, 31, 1'b0);
    send_slot(1'b0, 24'h333333, 0, 31, 1'b0);
    send_slot(1'b1, 24'h444444, 0, 31, 1'b0);
    send_slot(1'b0, 24'h555555, 0, 31, 1'b0);
    send_slot(1'b1, 24'h666666, 0, 31, 1'b0);
    repeat (4) @(negedge aud_mclk);
    tests_run++;
    if (fifo_level !== 3'd4) begin
      tests_failed++; $display("FAIL bp_level_full got=%0d exp=4", fifo_level);
    end
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++; $display("FAIL bp_overflow got=%b exp=1", overflow);
    end
    tests_run++;
    if (m_axis_aud_tdata !== 32'h01111110 || m_axis_aud_tid !== 3'd0) begin
      tests_failed++;
      $display("FAIL bp_head_stable got=%h/%0d exp=01111110/0", m_axis_aud_tdata, m_axis_aud_tid);
    end
    exp_q.push_back({3'd0, 32'h01111110});
    exp_q.push_back({3'd1, 32'h02222220});
    exp_q.push_back({3'd0, 32'h03333330});
    exp_q.push_back({3'd1, 32'h04444440});
    m_axis_aud_tready = 1'b1;
    wait_beats(4);
    repeat (10) @(negedge aud_mclk);
    check_beats("bp");
    tests_run++;
    if (fifo_level !== 3'd0) begin
      tests_failed++; $display("FAIL bp_level_drained got=%0d exp=0", fifo_level);
    end
    pulse_clr();
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++; $display("FAIL bp_overflow_clr got=%b exp=0", overflow);
    end
    finish_scenario();
  endtask

  task automatic test_short_slot;
    m_axis_aud_tready = 1'b1;
    preamble();
    send_slot(1'b0, 24'h777777, 0, 11, 1'b0);
    send_slot(1'b1, 24'h0F1E2D, 0, 31, 1'b0);
    exp_q.push_back({3'd1, 32'h00F1E2D0});
    wait_beats(1);
    repeat (20) @(negedge aud_mclk);
    check_beats("short");
    tests_run++;
    if (frame_err !== 1'b1) begin
      tests_failed++; $display("FAIL short_frame_err got=%b exp=1", frame_err);
    end
    pulse_clr();
    tests_run++;
    if (frame_err !== 1'b0) begin
      tests_failed++; $display("FAIL short_frame_err_clr got=%b exp=0", frame_err);
    end
    finish_scenario();
  endtask

  task automatic test_enable_drop;
    m_axis_aud_tready = 1'b1;
    preamble();
    send_slot(1'b0, 24'hABCDEF, 0, 13, 1'b0);
    @(negedge aud_mclk);
    enable = 1'b0;
    repeat (3) @(negedge aud_mclk);
    enable = 1'b1;
    send_slot(1'b0, 24'hABCDEF, 14, 31, 1'b0);
    send_slot(1'b1, 24'h123456, 0, 31, 1'b0);
    exp_q.push_back({3'd1, 32'h01234560});
    wait_beats(1);
    repeat (20) @(negedge aud_mclk);
    check_beats("en_drop");
    tests_run++;
    if (frame_err !== 1'b0) begin
      tests_failed++; $display("FAIL en_drop_frame_err got=%b exp=0", frame_err);
    end
    finish_scenario();
  endtask

  task automatic test_full_push_pop;
    m_axis_aud_tready = 1'b0;
    preamble();
    send_slot(1'b0, 24'h100001, 0, 31, 1'b0);
    send_slot(1'b1, 24'h200002, 0, 31, 1'b0);
    send_slot(1'b0, 24'h300003, 0, 31, 1'b0);
    send_slot(1'b1, 24'h400004, 0, 31, 1'b0);
    tests_run++;
    if (fifo_level !== 3'd4) begin
      tests_failed++; $display("FAIL fpp_level_before got=%0d exp=4", fifo_level);
    end
    // tready is raised for exactly the cycle in which the fifth sample is written
    send_slot(1'b0, 24'h500005, 0, 31, 1'b1);
    tests_run++;
    if (fifo_level !== 3'd4) begin
      tests_failed++; $display("FAIL fpp_level_after got=%0d exp=4", fifo_level);
    end
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++; $display("FAIL fpp_overflow got=%b exp=0", overflow);
    end
    tests_run++;
    if (got_q.size() !== 1) begin
      tests_failed++; $display("FAIL fpp_single_pop got=%0d exp=1", got_q.size());
    end
    exp_q.push_back({3'd0, 32'h01000010});
    exp_q.push_back({3'd1, 32'h02000020});
    exp_q.push_back({3'd0, 32'h03000030});
    exp_q.push_back({3'd1, 32'h04000040});
    exp_q.push_back({3'd0, 32'h05000050});
    m_axis_aud_tready = 1'b1;
    wait_beats(5);
    repeat (10) @(negedge aud_mclk);
    check_beats("fpp");
    finish_scenario();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    aud_mrst = 1'b1;
    enable = 1'b0;
    sclk_in = 1'b0;
    lrclk_in = 1'b0;
    sdata_in = 1'b0;
    m_axis_aud_tready = 1'b0;
    clr_status = 1'b0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_short_slot();
    test_enable_drop();
    test_full_push_pop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
